axi_stream_frame_fifo: RTL and testbench
========================================

# axi_stream_frame_fifo

Parametrised AXI-stream FIFO carrying `data`/`start`/`last` sideband, placed between any stream master and slave to buffer and decouple them. Adds configurable depth, an optional packet (store-and-forward) mode, frame accounting and sticky framing-error detection. Input side behaves as a slave endpoint and output side as a master endpoint of the team's stream interface.

## Interface
- `DATA_WIDTH`, 32, payload width in bits.
- `DEPTH`, 16, entries; power of two, ≥2.
- `PACKET_MODE`, 0, 1 = output held until a complete frame is buffered.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  DATA_WIDTH  input payload.
- `s_valid`  in  1  input beat valid.
- `s_start`  in  1  first beat of frame.
- `s_last`  in  1  final beat of frame.
- `s_ready`  out  1  FIFO can accept a beat.
- `m_data`  out  DATA_WIDTH  head payload.
- `m_valid`  out  1  head beat presentable.
- `m_start`  out  1  head beat start flag.
- `m_last`  out  1  head beat last flag.
- `m_ready`  in  1  downstream accepts.
- `count`  out  $clog2(DEPTH+1)  entries stored.
- `frames`  out  $clog2(DEPTH+1)  complete frames stored (stored beats with last=1).
- `err_framing`  out  1  sticky framing error.

## Operation
- Storage: DEPTH × (DATA_WIDTH+2) array; write/read pointers $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy tracked by `count`.
- Push = `s_valid && s_ready`; pop = `m_valid && m_ready`. Push writes {data,start,last} at wptr; pop advances rptr.
- `s_ready` = `count != DEPTH`. Full FIFO: push blocked; a pop that cycle frees space, visible next cycle.
- `count` next = count + push − pop; simultaneous push and pop leaves it unchanged.
- `frames` next = frames + (push && s_last) − (pop && m_last).
- `m_data/m_start/m_last` = entry at rptr (first-word fall-through); value undefined-but-stable when `m_valid`=0, driven 0 after reset.
- PACKET_MODE=0: `m_valid` = `count != 0`.
- PACKET_MODE=1: `m_valid` = `count != 0 && (frames != 0 || count == DEPTH || out_open)`. `out_open` set on pop with m_last=0, cleared on pop with m_last=1; once a frame starts draining it drains beat-by-beat. Full-with-no-complete-frame releases (cut-through fallback) to avoid deadlock on frames longer than DEPTH.
- Input framing FSM, states IDLE / IN_FRAME, advancing on push only:
  - IDLE, start=1,last=0 → IN_FRAME; start=1,last=1 → IDLE (single-beat frame).
  - IDLE, start=0 → error; state per `last` (0 → IN_FRAME, 1 → IDLE).
  - IN_FRAME, start=1 → error; last=1 → IDLE else stay.
- `err_framing` set on any error push; cleared only by `rst`. Erroneous beats are still stored unchanged.
- Output must never present a beat before it was pushed; no data reordering, no drops.

## Timing
- Reset (`rst`=1 at rising edge): pointers, `count`, `frames`, `out_open`, `err_framing` = 0; FSM = IDLE; `m_valid`=0, `s_ready`=1 from the cycle after reset; `m_data/m_start/m_last`=0. Reset mid-frame discards all content.
- Latency: push at edge N → `m_valid`=1 from cycle N+1 (mode 0). Mode 1: beat with last pushed at edge N → `m_valid`=1 at N+1.
- Throughput: one push and one pop per cycle sustained; no bubbles when neither side stalls.
- `s_ready`, `m_valid`, `count`, `frames` are functions of registered state only; `s_ready` independent of `m_ready`, `m_valid` independent of `s_valid` (no combinational path in→out).
- Masters must hold `s_*` stable while `s_valid && !s_ready`; FIFO holds `m_*` stable while `m_valid && !m_ready`.

## Test plan
- Reset then push 0x11,0x22,0x33 (start on first, last on third), `m_ready`=1 → same order out, `m_valid` first high cycle after first push, count returns 0, frames peaks 1, err_framing=0.
- DEPTH=16, `m_ready`=0, push 17 beats → 16 accepted, `s_ready`=0 at count=16; one pop → `s_ready`=1 next cycle; wrap-around over 40 beats preserves order.
- Simultaneous push/pop at count=5 for 100 cycles → count stays 5, data sequence intact.
- PACKET_MODE=1, push 4-beat frame with one idle cycle between beats → `m_valid`=0 until cycle after last beat, then 4 contiguous beats out; 20-beat frame into DEPTH=16 → output releases at count=16, whole frame delivered.
- Framing: start,start (no last between) and a beat with start=0 from IDLE → err_framing=1 at the offending push's next cycle, stays 1; data still delivered; `rst` clears it.
- Reset mid-frame with count=7 → next cycle count=0, frames=0, m_valid=0, s_ready=1, FSM accepts a fresh start without error.

Source files
------------

// File: rtl/axi_stream_frame_fifo.sv
// Stream FIFO carrying data/start/last. It can optionally hold output until a whole frame is stored.
// It also counts stored frames and keeps a sticky flag for malformed input framing.
module axi_stream_frame_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    input  logic                       s_start,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    output logic                       m_start,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] frames,
    output logic                       err_framing
);
    // state    | meaning
    // IDLE     | between frames, next beat must carry start
    // IN_FRAME | inside a frame, next beat must not carry start
    typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          out_open;
    logic          frame_ready;
    logic          push;
    logic          pop;
    state_t        state;

    assign head    = mem[rptr];
    assign m_data  = head[EW-1:2];
    assign m_start = head[1];
    assign m_last  = head[0];

    // A full FIFO with no complete frame releases anyway so oversized frames cannot deadlock.
    assign frame_ready = (frames != '0) || (count == FULL) || out_open;
    assign s_ready     = (count != FULL);
    assign m_valid     = (count != '0) && ((PACKET_MODE == 0) || frame_ready);
    assign push        = s_valid && s_ready;
    assign pop         = m_valid && m_ready;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= {s_data, s_start, s_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            frames   <= '0;
            out_open <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) begin
                rptr     <= rptr + AW'(1);
                out_open <= !m_last;
            end
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            case ({push && s_last, pop && m_last})
                2'b10:   frames <= frames + CW'(1);
                2'b01:   frames <= frames - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err_framing <= 1'b0;
        end else if (push) begin
            case (state)
                IDLE: begin
                    if (!s_start) err_framing <= 1'b1;
                    state <= s_last ? IDLE : IN_FRAME;
                end
                IN_FRAME: begin
                    if (s_start) err_framing <= 1'b1;
                    state <= s_last ? IDLE : IN_FRAME;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_frame_fifo.sv
// Directed bench: one streaming-mode instance and one packet-mode instance share the same stimulus.
module tb_axi_stream_frame_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0, s_start = 1'b0, s_last = 1'b0, m_ready = 1'b0;

    logic          a_s_ready, a_m_valid, a_m_start, a_m_last, a_err;
    logic [DW-1:0] a_m_data;
    logic [CW-1:0] a_count, a_frames;
    logic          p_s_ready, p_m_valid, p_m_start, p_m_last, p_err;
    logic [DW-1:0] p_m_data;
    logic [CW-1:0] p_count, p_frames;

    int tests = 0;
    int fails = 0;

    axi_stream_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_start(s_start),
        .s_last(s_last), .s_ready(a_s_ready), .m_data(a_m_data), .m_valid(a_m_valid),
        .m_start(a_m_start), .m_last(a_m_last), .m_ready(m_ready), .count(a_count),
        .frames(a_frames), .err_framing(a_err));

    axi_stream_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) dut_pkt (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_start(s_start),
        .s_last(s_last), .s_ready(p_s_ready), .m_data(p_m_data), .m_valid(p_m_valid),
        .m_start(p_m_start), .m_last(p_m_last), .m_ready(m_ready), .count(p_count),
        .frames(p_frames), .err_framing(p_err));

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic          st;
        logic          ls;
        logic          rdy;
        int            e_cnt;
        int            e_frm;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic          e_ms;
        logic          e_ml;
        logic          e_sr;
        logic          e_err;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [DW-1:0] d, input logic st, input logic ls,
                       input logic r);
        s_valid = v;
        s_data  = d;
        s_start = st;
        s_last  = ls;
        m_ready = r;
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd;
        bit first;

        vt[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 1, 1, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b1, 32'hB6, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 32'hB6, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b1, 32'hC7, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 32'hC7, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[8] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 32'hC7, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[9] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        // reset state of both instances
        rst_dut();
        chk("rst count", a_count, 0);
        chk("rst frames", a_frames, 0);
        chk("rst m_valid", a_m_valid, 0);
        chk("rst s_ready", a_s_ready, 1);
        chk("rst m_data", a_m_data, 0);
        chk("rst m_flags", {a_m_start, a_m_last}, 0);
        chk("rst err", a_err, 0);
        chk("rst pkt m_valid", p_m_valid, 0);
        chk("rst pkt s_ready", p_s_ready, 1);

        // table-driven streaming vectors
        for (int i = 0; i < 10; i++) begin
            drv(vt[i].vld, vt[i].data, vt[i].st, vt[i].ls, vt[i].rdy);
            step();
            chk($sformatf("vec%0d count", i), a_count, vt[i].e_cnt);
            chk($sformatf("vec%0d frames", i), a_frames, vt[i].e_frm);
            chk($sformatf("vec%0d m_valid", i), a_m_valid, vt[i].e_mv);
            chk($sformatf("vec%0d s_ready", i), a_s_ready, vt[i].e_sr);
            chk($sformatf("vec%0d err", i), a_err, vt[i].e_err);
            if (vt[i].e_mv) begin
                chk($sformatf("vec%0d m_data", i), a_m_data, vt[i].e_md);
                chk($sformatf("vec%0d m_start", i), a_m_start, vt[i].e_ms);
                chk($sformatf("vec%0d m_last", i), a_m_last, vt[i].e_ml);
            end
        end

        // fill to full, blocked push, one pop frees a slot
        rst_dut();
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 32'h100 + i, i == 0, 1'b0, 1'b0);
            step();
        end
        chk("full count", a_count, 16);
        chk("full s_ready", a_s_ready, 0);
        drv(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
        step();
        chk("blocked count", a_count, 16);
        chk("blocked head", a_m_data, 32'h100);
        m_ready = 1'b1;
        step();
        chk("pop-from-full count", a_count, 15);
        chk("pop-from-full s_ready", a_s_ready, 1);
        m_ready = 1'b0;
        step();
        chk("refill count", a_count, 16);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            chk($sformatf("full drain %0d", j), a_m_data, 32'h100 + j);
            step();
        end
        chk("full drained count", a_count, 0);
        chk("full frames", a_frames, 0);

        // 40 beats with a stalling consumer, pointers wrap twice
        rst_dut();
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 300 && rcvd < 40; cyc++) begin
            drv(sent < 40, 32'h200 + sent, (sent % 5) == 0, (sent % 5) == 4, (cyc % 3) != 0);
            if (a_m_valid && m_ready) begin
                chk($sformatf("wrap data %0d", rcvd), a_m_data, 32'h200 + rcvd);
                chk($sformatf("wrap last %0d", rcvd), a_m_last, (rcvd % 5) == 4);
                rcvd++;
            end
            if (s_valid && a_s_ready) sent++;
            step();
        end
        chk("wrap received", rcvd, 40);
        chk("wrap count", a_count, 0);
        chk("wrap frames", a_frames, 0);
        chk("wrap err", a_err, 0);

        // steady push+pop at count=5
        rst_dut();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 32'h300 + i, 1'b1, 1'b1, 1'b0);
            step();
        end
        chk("steady prefill", a_count, 5);
        for (int k = 0; k < 100; k++) begin
            drv(1'b1, 32'h305 + k, 1'b1, 1'b1, 1'b1);
            chk($sformatf("steady data %0d", k), a_m_data, 32'h300 + k);
            step();
            chk($sformatf("steady count %0d", k), a_count, 5);
        end
        chk("steady frames", a_frames, 5);

        // packet mode: 4-beat frame with gaps is held until its last beat
        rst_dut();
        for (int b = 0; b < 4; b++) begin
            drv(1'b1, 32'h400 + b, b == 0, b == 3, 1'b1);
            step();
            if (b < 3) begin
                chk($sformatf("pkt hold beat%0d", b), p_m_valid, 0);
                drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
                step();
                chk($sformatf("pkt hold gap%0d", b), p_m_valid, 0);
            end
        end
        chk("pkt release", p_m_valid, 1);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("pkt out valid %0d", b), p_m_valid, 1);
            chk($sformatf("pkt out data %0d", b), p_m_data, 32'h400 + b);
            step();
        end
        chk("pkt empty valid", p_m_valid, 0);
        chk("pkt empty count", p_count, 0);

        // packet mode: 20-beat frame releases at full
        rst_dut();
        sent  = 0;
        rcvd  = 0;
        first = 0;
        for (int cyc = 0; cyc < 100 && rcvd < 20; cyc++) begin
            drv(sent < 20, 32'h500 + sent, sent == 0, sent == 19, 1'b1);
            if (p_m_valid && !first) begin
                first = 1;
                chk("pkt cut-through count", p_count, 16);
            end
            if (p_m_valid && m_ready) begin
                chk($sformatf("pkt long data %0d", rcvd), p_m_data, 32'h500 + rcvd);
                rcvd++;
            end
            if (s_valid && p_s_ready) sent++;
            step();
        end
        chk("pkt long received", rcvd, 20);
        chk("pkt long count", p_count, 0);
        chk("pkt long frames", p_frames, 0);
        chk("pkt long err", p_err, 0);

        // framing errors: missing start from idle, then start inside a frame
        rst_dut();
        drv(1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
        step();
        chk("err no-start", a_err, 1);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("err sticky", a_err, 1);
        rst_dut();
        chk("err cleared by rst", a_err, 0);
        drv(1'b1, 32'h610, 1'b1, 1'b0, 1'b0);
        step();
        chk("err good start", a_err, 0);
        drv(1'b1, 32'h611, 1'b1, 1'b1, 1'b0);
        step();
        chk("err double start", a_err, 1);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("err double sticky", a_err, 1);
        m_ready = 1'b1;
        chk("err beat0 data", a_m_data, 32'h610);
        chk("err beat0 flags", {a_m_start, a_m_last}, 2'b10);
        step();
        chk("err beat1 data", a_m_data, 32'h611);
        chk("err beat1 flags", {a_m_start, a_m_last}, 2'b11);
        step();
        chk("err drained", a_m_valid, 0);
        chk("err after drain", a_err, 1);

        // reset in the middle of a frame
        rst_dut();
        for (int i = 0; i < 7; i++) begin
            drv(1'b1, 32'h700 + i, i == 0, 1'b0, 1'b0);
            step();
        end
        chk("mid count 7", a_count, 7);
        rst_dut();
        chk("mid rst count", a_count, 0);
        chk("mid rst frames", a_frames, 0);
        chk("mid rst m_valid", a_m_valid, 0);
        chk("mid rst s_ready", a_s_ready, 1);
        chk("mid rst pkt count", p_count, 0);
        drv(1'b1, 32'h7F0, 1'b1, 1'b1, 1'b1);
        step();
        chk("mid fresh err", a_err, 0);
        chk("mid fresh count", a_count, 1);
        chk("mid fresh frames", a_frames, 1);
        chk("mid fresh data", a_m_data, 32'h7F0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
